// File: rtl/clock_setter.sv
// rtl/clock_setter.sv - time-setting front end for the BCD 24-hour clock
// Two debounced buttons drive an edit session that snapshots, steps and reloads hh:mm:ss.
module clock_setter #(
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned TIMEOUT    = 500_000_000,
  parameter int unsigned BLINK_HALF = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BT_mode,
  input  logic       BT_inc,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic [7:0] cur_ss,
  output logic [7:0] set_hh,
  output logic [7:0] set_mm,
  output logic [7:0] set_ss,
  output logic       load,
  output logic       editing,
  output logic [2:0] blink
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_MAX  = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EDIT_H, S_EDIT_M, S_EDIT_S, S_COMMIT
  } state_t;

  // Index 0 is the mode button, index 1 the increment button.
  logic [1:0]    w_raw;
  logic [1:0]    r_sync1, r_sync2, r_deb, r_deb_d, r_pulse;
  logic [DW-1:0] r_deb_cnt [2];
  logic          w_mode_p, w_inc_p;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_ph;
  logic [TW-1:0] r_idle;
  state_t        r_state;
  logic [2:0]    w_sel;

  assign w_raw    = {~BT_inc, ~BT_mode};
  assign w_mode_p = r_pulse[0];
  assign w_inc_p  = r_pulse[1];

  // Illegal fields (bad low digit or past the field maximum) restart at zero.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v[3:0] > 4'd9 || v >= max) return 8'h00;
    else if (v[3:0] == 4'd9)        return {v[7:4] + 4'd1, 4'd0};
    else                            return v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_pulse <= '0;
      for (int i = 0; i < 2; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      r_pulse <= r_deb & ~r_deb_d;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_deb_cnt[i] == DEB_MAX) begin
            r_deb[i]     <= r_sync2[i];
            r_deb_cnt[i] <= '0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
          end
        end else begin
          r_deb_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else if (r_blink_cnt == BLINK_MAX) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= ~r_blink_ph;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // mode_p is tested before inc_p, so a coincident increment is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idle  <= '0;
      set_hh  <= 8'h00;
      set_mm  <= 8'h00;
      set_ss  <= 8'h00;
      load    <= 1'b0;
      editing <= 1'b0;
    end else begin
      load <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_idle <= '0;
          if (w_mode_p) begin
            set_hh  <= cur_hh;
            set_mm  <= cur_mm;
            set_ss  <= cur_ss;
            r_state <= S_EDIT_H;
            editing <= 1'b1;
          end
        end
        S_EDIT_H, S_EDIT_M, S_EDIT_S: begin
          if (w_mode_p) begin
            r_idle <= '0;
            case (r_state)
              S_EDIT_H: r_state <= S_EDIT_M;
              S_EDIT_M: r_state <= S_EDIT_S;
              default: begin
                r_state <= S_COMMIT;
                load    <= 1'b1;
                editing <= 1'b0;
              end
            endcase
          end else if (w_inc_p) begin
            r_idle <= '0;
            case (r_state)
              S_EDIT_H: set_hh <= bcd_inc(set_hh, 8'h23);
              S_EDIT_M: set_mm <= bcd_inc(set_mm, 8'h59);
              default:  set_ss <= bcd_inc(set_ss, 8'h59);
            endcase
          end else if (r_idle == IDLE_MAX) begin
            r_idle  <= '0;
            r_state <= S_IDLE;
            editing <= 1'b0;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
        end
        S_COMMIT: r_state <= S_IDLE;
        default: begin
          r_state <= S_IDLE;
          editing <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_sel = 3'b000;
    case (r_state)
      S_EDIT_H: w_sel = 3'b100;
      S_EDIT_M: w_sel = 3'b010;
      S_EDIT_S: w_sel = 3'b001;
      default:  w_sel = 3'b000;
    endcase
  end

  assign blink = w_sel & {3{r_blink_ph}};

endmodule
